// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, common keyboard
// commands and the odd-parity helper used when framing a byte.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RECOVER = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions the asynchronous PS/2 pad inputs: 2-flop synchronizers, a
// run-length glitch filter on the clock line and a one-cycle falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          clk_meta_r;
  logic          clk_sync_r;
  logic          data_meta_r;
  logic          data_sync_r;
  logic          filt_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  logic          filt_s;
  logic          fall_s;
  logic [CW-1:0] cnt_s;

  // filter next-state: counts consecutive samples that disagree with the filtered level
  always_comb begin
    filt_s = filt_r;
    fall_s = 1'b0;
    cnt_s  = {CW{1'b0}};
    if (clk_sync_r == filt_r) begin
      cnt_s = {CW{1'b0}};
    end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
      filt_s = clk_sync_r;
      fall_s = ~clk_sync_r;
      cnt_s  = {CW{1'b0}};
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // synchronizer and filter registers; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      filt_r      <= 1'b1;
      fall_r      <= 1'b0;
      cnt_r       <= {CW{1'b0}};
    end else begin
      clk_meta_r  <= ps2_clk_i;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data_i;
      data_sync_r <= data_meta_r;
      filt_r      <= filt_s;
      fall_r      <= fall_s;
      cnt_r       <= cnt_s;
    end
  end

  assign clk_filt  = filt_r;
  assign data_sync = data_sync_r;
  assign fall      = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, then
// shifts one command byte out on device-generated clock edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = 12000,
  parameter int START_HOLD_CYCLES = 200,
  parameter int TIMEOUT_CYCLES    = 2000000,
  parameter int FILTER_LEN        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  logic clk_filt_s;
  logic data_sync_s;
  logic fall_s;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_filt  (clk_filt_s),
    .data_sync (data_sync_s),
    .fall      (fall_s)
  );

  ps2_state_e  state_r, state_s;
  logic [31:0] cyc_r, cyc_s;
  logic [31:0] to_r, to_s;
  logic [3:0]  edge_r, edge_s;
  logic [7:0]  byte_r, byte_s;
  logic        par_r, par_s;
  logic        clk_oe_r, clk_oe_s;
  logic        data_oe_r, data_oe_s;
  logic        done_r, done_s;
  logic        ack_r, ack_s;
  logic        err_r, err_s;
  logic        tx_ready_r;
  logic        busy_r;

  // next-state and next-output logic
  always_comb begin
    state_s   = state_r;
    cyc_s     = cyc_r;
    to_s      = to_r;
    edge_s    = edge_r;
    byte_s    = byte_r;
    par_s     = par_r;
    clk_oe_s  = clk_oe_r;
    data_oe_s = data_oe_r;
    done_s    = 1'b0;
    ack_s     = ack_r;
    err_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        if (tx_valid && tx_ready_r) begin
          byte_s   = tx_data;
          par_s    = odd_parity(tx_data);
          ack_s    = 1'b0;
          cyc_s    = 32'd0;
          clk_oe_s = 1'b1;
          state_s  = ST_INHIBIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        clk_oe_s = 1'b1;
        if (cyc_r == 32'(INHIBIT_CYCLES - 1)) begin
          cyc_s     = 32'd0;
          data_oe_s = 1'b1;
          state_s   = ST_START;
        end else begin
          cyc_s = cyc_r + 32'd1;
        end
      end
      ST_START: begin
        clk_oe_s  = 1'b1;
        data_oe_s = 1'b1;
        if (cyc_r == 32'(START_HOLD_CYCLES - 1)) begin
          clk_oe_s = 1'b0;
          edge_s   = 4'd0;
          to_s     = 32'd0;
          state_s  = ST_SHIFT;
        end else begin
          cyc_s = cyc_r + 32'd1;
        end
      end
      ST_SHIFT, ST_ACK: begin
        // timeout has priority over a coincident falling edge
        if (to_r == 32'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_s  = 1'b0;
          data_oe_s = 1'b0;
          ack_s     = 1'b0;
          err_s     = 1'b1;
          done_s    = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          to_s = to_r + 32'd1;
          if (fall_s && (state_r == ST_ACK)) begin
            ack_s   = ~data_sync_s;
            state_s = ST_RECOVER;
          end else if (fall_s) begin
            edge_s = edge_r + 4'd1;
            case (edge_r)
              4'd0, 4'd1, 4'd2, 4'd3,
              4'd4, 4'd5, 4'd6, 4'd7: data_oe_s = ~byte_r[edge_r[2:0]];
              4'd8:    data_oe_s = ~par_r;
              4'd9: begin
                data_oe_s = 1'b0;
                state_s   = ST_ACK;
              end
              default: data_oe_s = 1'b0;
            endcase
          end else begin
            state_s = state_r;
          end
        end
      end
      ST_RECOVER: begin
        if (clk_filt_s && data_sync_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RECOVER;
        end
      end
      default: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs; ready is withheld during the done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cyc_r      <= 32'd0;
      to_r       <= 32'd0;
      edge_r     <= 4'd0;
      byte_r     <= 8'd0;
      par_r      <= 1'b0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      done_r     <= 1'b0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cyc_r      <= cyc_s;
      to_r       <= to_s;
      edge_r     <= edge_s;
      byte_r     <= byte_s;
      par_r      <= par_s;
      clk_oe_r   <= clk_oe_s;
      data_oe_r  <= data_oe_s;
      done_r     <= done_s;
      ack_r      <= ack_s;
      err_r      <= err_s;
      tx_ready_r <= (state_s == ST_IDLE) && !done_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign tx_ready    = tx_ready_r;
  assign busy        = busy_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign done        = done_r;
  assign ack_ok      = ack_r;
  assign err_timeout = err_r;

endmodule
